sram_arb_bridge: RTL and testbench

- Parametrised successor to the CPU-side SRAM-to-cache bridge.
- Accepts one instruction fetch and one optional data access per CPU step from sram-style CPU ports.
- Serialises them onto a single unified memory request port with a ready/valid handshake, and holds the CPU stalled until both accesses complete.
- Adds a selectable service order, a request-accept handshake, registered read-data hold, and flush with drain.

---
 rtl/sram_arb_bridge.sv | 141 ++++++++++++++
 tb/tb_sram_arb_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_bridge.sv
// Bridges sram-style fetch and data CPU ports onto one ready/valid memory port,
// serialising up to two accesses per CPU step and stalling the CPU until they finish.
module sram_arb_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_ren,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                cpu_stall,
    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        StIdle, StReqA, StWaitA, StReqB, StWaitB, StDone, StDrain
    } state_e;

    typedef struct packed {
        logic              is_data;
        logic [STRB_W-1:0] we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

    state_e state_q, state_d;
    slot_t  slot_a_q, slot_a_d, slot_b_q, slot_b_d;
    logic   b_valid_q, b_valid_d;
    slot_t  d_slot, i_slot, cur;
    logic   dpend, cap_inst, cap_data;

    assign dpend = data_ren | (|data_wen);

    // Reads carry zero strobes and zero write data; a write wins over a read.
    always_comb begin
        d_slot         = '0;
        d_slot.is_data = 1'b1;
        d_slot.we      = data_wen;
        d_slot.addr    = data_addr;
        d_slot.wdata   = (|data_wen) ? data_wdata : '0;
        i_slot         = '0;
        i_slot.addr    = inst_addr;
    end

    assign cur = (state_q == StReqB || state_q == StWaitB) ? slot_b_q : slot_a_q;

    always_comb begin
        state_d   = state_q;
        slot_a_d  = slot_a_q;
        slot_b_d  = slot_b_q;
        b_valid_d = b_valid_q;
        cap_inst  = 1'b0;
        cap_data  = 1'b0;
        cpu_stall = 1'b1;
        mem_req   = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            StIdle: begin
                cpu_stall = inst_req | dpend;
                if (inst_req && dpend) begin
                    slot_a_d  = DATA_FIRST ? d_slot : i_slot;
                    slot_b_d  = DATA_FIRST ? i_slot : d_slot;
                    b_valid_d = 1'b1;
                    state_d   = StReqA;
                end else if (inst_req || dpend) begin
                    slot_a_d  = inst_req ? i_slot : d_slot;
                    b_valid_d = 1'b0;
                    state_d   = StReqA;
                end
            end
            StReqA, StReqB: begin
                mem_req   = 1'b1;
                mem_we    = cur.we;
                mem_addr  = cur.addr;
                mem_wdata = cur.wdata;
                if (flush) begin
                    // An accepted request still owes a response that must be drained.
                    state_d = mem_ready ? StDrain : StDone;
                end else if (mem_ready) begin
                    state_d = (state_q == StReqA) ? StWaitA : StWaitB;
                end
            end
            StWaitA, StWaitB: begin
                if (mem_valid) begin
                    if (!flush && cur.we == '0) begin
                        cap_data = cur.is_data;
                        cap_inst = ~cur.is_data;
                    end
                    state_d = (state_q == StWaitA && b_valid_q && !flush) ? StReqB : StDone;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_valid) state_d = StDone;
            end
            StDone: begin
                cpu_stall = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            slot_a_q   <= '0;
            slot_b_q   <= '0;
            b_valid_q  <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            state_q   <= state_d;
            slot_a_q  <= slot_a_d;
            slot_b_q  <= slot_b_d;
            b_valid_q <= b_valid_d;
            if (cap_inst) inst_rdata <= mem_rdata;
            if (cap_data) data_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_arb_bridge.sv
// Drives both service orders side by side with directed and random CPU steps and
// checks requests, stall timing and captured data against a per-step access-list model.
module tb_sram_arb_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, inst_req, data_ren, mem_ready, mem_valid;
    logic [3:0]  data_wen;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [31:0] inst_rdata [2];
    logic [31:0] data_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [3:0]  mem_we [2];
    logic        cpu_stall [2];
    logic        mem_req [2];

    // Instance k uses DATA_FIRST = k.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        sram_arb_bridge #(
            .ADDR_W(32),
            .DATA_W(32),
            .DATA_FIRST(k == 1)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .inst_req   (inst_req),
            .inst_addr  (inst_addr),
            .inst_rdata (inst_rdata[k]),
            .data_ren   (data_ren),
            .data_wen   (data_wen),
            .data_addr  (data_addr),
            .data_wdata (data_wdata),
            .data_rdata (data_rdata[k]),
            .cpu_stall  (cpu_stall[k]),
            .mem_req    (mem_req[k]),
            .mem_we     (mem_we[k]),
            .mem_addr   (mem_addr[k]),
            .mem_wdata  (mem_wdata[k]),
            .mem_ready  (mem_ready),
            .mem_valid  (mem_valid),
            .mem_rdata  (mem_rdata[k])
        );
    end

    typedef struct {
        bit          is_data;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_inst [2];
    logic [31:0] exp_data [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic clear_cpu();
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_ren   = 1'b0;
        data_wen   = '0;
        data_addr  = '0;
        data_wdata = '0;
    endtask

    task automatic chk_rdata(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_inst_rdata"}, k, inst_rdata[k], exp_inst[k]);
            chk({tag, "_data_rdata"}, k, data_rdata[k], exp_data[k]);
        end
    endtask

    // mode: 0 none, 1 flush in first WAIT of access 0, 2 flush in REQ with ready low,
    // 3 flush in REQ with ready high, 4 reset in first WAIT of access 1.
    // Called and returns at a negedge with the bridge idle.
    task automatic run_step(input bit ireq, input logic [31:0] iaddr, input bit dren,
                            input logic [3:0] dwen, input logic [31:0] daddr,
                            input logic [31:0] dwdata, input int rd0, input int vd0,
                            input int rd1, input int vd1, input logic [31:0] r0,
                            input logic [31:0] r1, input int mode);
        acc_t        acc [2][2];
        acc_t        ia, da;
        bit          hasd, aborted;
        int          n, rd, vd;
        logic [31:0] rsp;
        hasd       = dren || (dwen != 4'h0);
        n          = int'(ireq) + int'(hasd);
        ia.is_data = 1'b0; ia.we = 4'h0; ia.addr = iaddr; ia.wdata = 32'h0;
        da.is_data = 1'b1; da.we = dwen; da.addr = daddr;
        da.wdata   = (dwen != 4'h0) ? dwdata : 32'h0;
        for (int k = 0; k < 2; k++) begin
            if (ireq && hasd) begin
                acc[k][0] = (k == 1) ? da : ia;
                acc[k][1] = (k == 1) ? ia : da;
            end else begin
                acc[k][0] = ireq ? ia : da;
            end
        end
        inst_req = ireq; inst_addr = iaddr; data_ren = dren; data_wen = dwen;
        data_addr = daddr; data_wdata = dwdata;
        flush = 1'(($urandom % 2));
        mem_ready = 1'(($urandom % 2));
        mem_valid = 1'(($urandom % 2));
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("idle_stall", k, 32'(cpu_stall[k]), 32'(n != 0));
            chk("idle_req", k, 32'(mem_req[k]), 32'h0);
        end
        @(negedge clk);
        if (n == 0) begin
            chk_rdata("idle_hold");
            return;
        end
        aborted = 1'b0;
        for (int j = 0; j < n; j++) begin
            rd  = (j == 0) ? rd0 : rd1;
            vd  = (j == 0) ? vd0 : vd1;
            rsp = (j == 0) ? r0 : r1;
            for (int c = 0; c <= rd; c++) begin
                for (int k = 0; k < 2; k++) begin
                    chk("req_valid", k, 32'(mem_req[k]), 32'h1);
                    chk("req_addr", k, mem_addr[k], acc[k][j].addr);
                    chk("req_we", k, 32'(mem_we[k]), 32'(acc[k][j].we));
                    chk("req_wdata", k, mem_wdata[k], acc[k][j].wdata);
                    chk("req_stall", k, 32'(cpu_stall[k]), 32'h1);
                    mem_rdata[k] = $urandom;
                end
                mem_ready = (c == rd);
                mem_valid = 1'(($urandom % 2));
                flush = (j == 0) && ((mode == 2 && c == 0) || (mode == 3 && c == rd));
                @(negedge clk);
                flush = 1'b0;
                if (mode == 2 && j == 0) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) break;
            for (int c = 0; c <= vd; c++) begin
                for (int k = 0; k < 2; k++) begin
                    chk("wait_req", k, 32'(mem_req[k]), 32'h0);
                    chk("wait_stall", k, 32'(cpu_stall[k]), 32'h1);
                    mem_rdata[k] = (c == vd) ? rsp : $urandom;
                end
                if (mode == 4 && j == 1 && c == 0) begin
                    rst = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_ready = 1'b0;
                    clear_cpu();
                    @(negedge clk);
                    rst = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        exp_inst[k] = '0;
                        exp_data[k] = '0;
                        chk("rst_req", k, 32'(mem_req[k]), 32'h0);
                        chk("rst_stall", k, 32'(cpu_stall[k]), 32'h0);
                        mem_rdata[k] = 32'hA5A5_5A5A;
                    end
                    chk_rdata("rst");
                    mem_valid = 1'b1;
                    @(negedge clk);
                    mem_valid = 1'b0;
                    for (int k = 0; k < 2; k++) chk("rst_late_req", k, 32'(mem_req[k]), 32'h0);
                    chk_rdata("rst_late");
                    return;
                end
                mem_ready = 1'(($urandom % 2));
                mem_valid = (c == vd);
                flush = (mode == 1 && j == 0 && c == 0);
                @(negedge clk);
                flush = 1'b0;
            end
            if ((mode == 1 || mode == 3) && j == 0) break;
            for (int k = 0; k < 2; k++) begin
                if (acc[k][j].we == 4'h0) begin
                    if (acc[k][j].is_data) exp_data[k] = rsp;
                    else exp_inst[k] = rsp;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("done_stall", k, 32'(cpu_stall[k]), 32'h0);
            chk("done_req", k, 32'(mem_req[k]), 32'h0);
        end
        chk_rdata("done");
        mem_valid = 1'(($urandom % 2));
        mem_ready = 1'(($urandom % 2));
        flush = 1'(($urandom % 2));
        @(negedge clk);
        flush = 1'b0; mem_valid = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        bit         ireq, dren;
        logic [3:0] dwen;
        int         mode;
        rst = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0;
        mem_rdata[0] = '0; mem_rdata[1] = '0;
        clear_cpu();
        for (int k = 0; k < 2; k++) begin
            exp_inst[k] = '0;
            exp_data[k] = '0;
        end
        repeat (2) @(negedge clk);
        inst_req = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_req", k, 32'(mem_req[k]), 32'h0);
            chk("reset_addr", k, mem_addr[k], 32'h0);
            chk("reset_we", k, 32'(mem_we[k]), 32'h0);
            chk("reset_wdata", k, mem_wdata[k], 32'h0);
            chk("reset_stall", k, 32'(cpu_stall[k]), 32'h1);
        end
        chk_rdata("reset");
        clear_cpu();
        @(negedge clk);
        rst = 1'b1;

        run_step(1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0,
                 32'h3C08_0001, 32'h0, 0);
        run_step(1, 32'hBFC0_0004, 1, 4'h0, 32'h8000_0010, 32'h0, 0, 0, 0, 0,
                 32'h1111_2222, 32'h3333_4444, 0);
        run_step(0, 32'h0, 0, 4'b0011, 32'h8000_0020, 32'hDEAD_BEEF, 3, 0, 0, 0,
                 32'h7777_7777, 32'h0, 0);
        run_step(1, 32'hBFC0_0008, 1, 4'hF, 32'h8000_0024, 32'hCAFE_F00D, 1, 1, 0, 2,
                 32'h5555_6666, 32'h9999_AAAA, 0);
        run_step(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        run_step(1, 32'hBFC0_000C, 1, 4'h0, 32'h8000_0030, 32'h0, 0, 2, 0, 0,
                 32'hBAD0_0001, 32'hBAD0_0002, 1);
        run_step(1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_0034, 32'h0, 2, 0, 0, 0,
                 32'hBAD0_0003, 32'hBAD0_0004, 2);
        run_step(1, 32'hBFC0_0014, 0, 4'h0, 32'h0, 32'h0, 1, 1, 0, 0,
                 32'hBAD0_0005, 32'h0, 3);
        run_step(1, 32'hBFC0_0018, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0,
                 32'h0123_4567, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            ireq = 1'(($urandom % 2));
            dren = 1'(($urandom % 2));
            dwen = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
            mode = ($urandom % 6 == 0) ? 3 : 0;
            run_step(ireq, $urandom, dren, dwen, $urandom, $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom, $urandom, mode);
        end

        run_step(1, 32'hBFC0_0020, 1, 4'h0, 32'h8000_0040, 32'h0, 0, 0, 0, 0,
                 32'hFEED_0001, 32'hFEED_0002, 4);
        run_step(0, 32'h0, 1, 4'h0, 32'h8000_0044, 32'h0, 0, 1, 0, 0,
                 32'h2468_ACE0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
